single_cycle_cpu: RTL and testbench

- 64-bit single-cycle LEGv8-style (ARMv8 subset) processor with an on-chip instruction ROM holding built-in test program 1.
- Includes on-chip data memory and a 32x64 register file.
- Each instruction completes in one CLK cycle.
- Top-level execution block for processor bring-up; the bench observes only PC and the last loaded value.

---
 rtl/single_cycle_cpu.sv | 158 +++++++++++++++
 tb/tb_single_cycle_cpu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_cpu.sv
// Single-cycle 64-bit LEGv8-subset core with built-in test program ROM, data memory and register file.
// Optional macro CBNZ_EN adds the CBNZ branch (opcode[31:24]=10110101); otherwise that encoding is a NOP.
module single_cycle_cpu #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 32
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [63:0] startPC,
  output logic [63:0] currentPC,
  output logic [63:0] dMemOut
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned IA_W  = $clog2(IMEM_WORDS);
  localparam int unsigned DA_W  = $clog2(DMEM_WORDS);

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
`ifdef CBNZ_EN
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
`endif
  localparam logic [5:0]  OP_B    = 6'b000101;

  // Test program 1; unlisted words are zero (decoded as NOP).
  function automatic logic [31:0] rom_word(input int unsigned idx);
    case (idx)
      0:       return 32'hF84003E9; // LDUR X9,[XZR,#0]
      1:       return 32'hF84083EA; // LDUR X10,[XZR,#8]
      2:       return 32'hF84103EB; // LDUR X11,[XZR,#16]
      3:       return 32'h8B0B014C; // ADD  X12,X10,X11
      4:       return 32'hCB09018D; // SUB  X13,X12,X9
      5:       return 32'hAA0901AE; // ORR  X14,X13,X9
      6:       return 32'h8A0C01CF; // AND  X15,X14,X12
      7:       return 32'hB400005F; // CBZ  XZR,#2
      8:       return 32'h8B0901EF; // ADD  X15,X15,X9
      9:       return 32'hF80203EF; // STUR X15,[XZR,#32]
      10:      return 32'h14000002; // B    #2
      11:      return 32'hF80203FF; // STUR XZR,[XZR,#32]
      12:      return 32'hF84203F0; // LDUR X16,[XZR,#32]
      13:      return 32'h14000000; // B    #0
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] dmem_init(input int unsigned idx);
    case (idx)
      0:       return XLEN'(64'h1);
      1:       return XLEN'(64'hA);
      2:       return XLEN'(64'h5);
      default: return '0;
    endcase
  endfunction

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] load_q;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] dmem [DMEM_WORDS];

  logic [31:0]     instr;
  logic [4:0]      rd, rn, rm;
  logic [XLEN-1:0] rn_val, rm_val, rt_val;
  logic [XLEN-1:0] imm9_x, imm19_x, imm26_x;
  logic [XLEN-1:0] addr;
  logic [DA_W-1:0] didx;
  logic [XLEN-1:0] next_pc, reg_wd;
  logic            reg_we, mem_we, ld_en;
  logic            unused_addr_bits;

  assign instr  = rom_word(32'(pc[IA_W+1:2]));
  assign rd     = instr[4:0];
  assign rn     = instr[9:5];
  assign rm     = instr[20:16];
  assign rn_val = (rn == 5'd31) ? '0 : regs[rn];
  assign rm_val = (rm == 5'd31) ? '0 : regs[rm];
  assign rt_val = (rd == 5'd31) ? '0 : regs[rd];

  assign imm9_x  = {{(XLEN-9){instr[20]}},  instr[20:12]};
  assign imm19_x = {{(XLEN-19){instr[23]}}, instr[23:5]};
  assign imm26_x = {{(XLEN-26){instr[25]}}, instr[25:0]};

  assign addr = rn_val + imm9_x;
  assign didx = addr[DA_W+2:3];
  assign unused_addr_bits = ^{addr[XLEN-1:DA_W+3], addr[2:0]};

  // Decode/execute: everything resolves combinationally within the cycle.
  always_comb begin
    next_pc = pc + XLEN'(4);
    reg_we  = 1'b0;
    reg_wd  = '0;
    mem_we  = 1'b0;
    ld_en   = 1'b0;
    if (instr[31:21] == OP_LDUR) begin
      reg_we = 1'b1;
      reg_wd = dmem[didx];
      ld_en  = 1'b1;
    end else if (instr[31:21] == OP_STUR) begin
      mem_we = 1'b1;
    end else if (instr[31:21] == OP_ADD) begin
      reg_we = 1'b1;
      reg_wd = rn_val + rm_val;
    end else if (instr[31:21] == OP_SUB) begin
      reg_we = 1'b1;
      reg_wd = rn_val - rm_val;
    end else if (instr[31:21] == OP_AND) begin
      reg_we = 1'b1;
      reg_wd = rn_val & rm_val;
    end else if (instr[31:21] == OP_ORR) begin
      reg_we = 1'b1;
      reg_wd = rn_val | rm_val;
    end else if (instr[31:24] == OP_CBZ) begin
      if (rt_val == '0) next_pc = pc + (imm19_x << 2);
`ifdef CBNZ_EN
    end else if (instr[31:24] == OP_CBNZ) begin
      if (rt_val != '0) next_pc = pc + (imm19_x << 2);
`endif
    end else if (instr[31:26] == OP_B) begin
      next_pc = pc + (imm26_x << 2);
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      pc     <= startPC;
      load_q <= '0;
    end else begin
      pc <= next_pc;
      if (ld_en) load_q <= reg_wd;
    end
  end

  // X31 is never written, so its entry stays at its reset value.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_we && (rd != 5'd31)) begin
      regs[rd] <= reg_wd;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int unsigned i = 0; i < DMEM_WORDS; i++) dmem[i] <= dmem_init(i);
    end else if (mem_we) begin
      dmem[didx] <= rt_val;
    end
  end

  assign currentPC = pc;
  assign dMemOut   = load_q;

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: instruction-level reference model compared every cycle, plus literal program-1 expectations.
module tb_single_cycle_cpu;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic [63:0] startPC = 64'd0;
  logic [63:0] currentPC;
  logic [63:0] dMemOut;

  int checks = 0;
  int failures = 0;
  bit en = 1'b0;

  always #5 CLK = ~CLK;

  single_cycle_cpu dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .startPC   (startPC),
    .currentPC (currentPC),
    .dMemOut   (dMemOut)
  );

  // Reference machine state, written from the assembly listing.
  logic [31:0] rom   [64];
  logic [63:0] m_reg [32];
  logic [63:0] m_mem [32];
  logic [63:0] m_pc;
  logic [63:0] m_out;

  initial begin
    foreach (rom[i]) rom[i] = 32'h0;
    rom[0]  = 32'hF84003E9; rom[1]  = 32'hF84083EA; rom[2]  = 32'hF84103EB;
    rom[3]  = 32'h8B0B014C; rom[4]  = 32'hCB09018D; rom[5]  = 32'hAA0901AE;
    rom[6]  = 32'h8A0C01CF; rom[7]  = 32'hB400005F; rom[8]  = 32'h8B0901EF;
    rom[9]  = 32'hF80203EF; rom[10] = 32'h14000002; rom[11] = 32'hF80203FF;
    rom[12] = 32'hF84203F0; rom[13] = 32'h14000000;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v, input int unsigned bits);
    logic signed [63:0] s;
    s = $signed(v << (64 - bits));
    return 64'(s >>> (64 - bits));
  endfunction

  function automatic logic [63:0] xr(input logic [4:0] i);
    return (i == 5'd31) ? 64'd0 : m_reg[i];
  endfunction

  task automatic model_reset();
    m_pc  = startPC;
    m_out = 64'd0;
    foreach (m_reg[i]) m_reg[i] = 64'd0;
    foreach (m_mem[i]) m_mem[i] = 64'd0;
    m_mem[0] = 64'h1;
    m_mem[1] = 64'hA;
    m_mem[2] = 64'h5;
  endtask

  task automatic model_step();
    logic [31:0] ins;
    logic [63:0] a, b, t, ea, res;
    int unsigned idx;
    bit wr;
    ins = rom[32'((m_pc >> 2) % 64'd64)];
    a   = xr(ins[9:5]);
    b   = xr(ins[20:16]);
    t   = xr(ins[4:0]);
    ea  = a + sx(64'(ins[20:12]), 9);
    idx = 32'((ea >> 3) % 64'd32);
    wr  = 1'b0;
    res = 64'd0;
    m_pc = m_pc + 64'd4;
    if (ins[31:21] == 11'h7C2) begin
      res = m_mem[idx]; wr = 1'b1; m_out = m_mem[idx];
    end else if (ins[31:21] == 11'h7C0) begin
      m_mem[idx] = t;
    end else if (ins[31:21] == 11'h458) begin
      res = a + b; wr = 1'b1;
    end else if (ins[31:21] == 11'h658) begin
      res = a - b; wr = 1'b1;
    end else if (ins[31:21] == 11'h450) begin
      res = a & b; wr = 1'b1;
    end else if (ins[31:21] == 11'h550) begin
      res = a | b; wr = 1'b1;
    end else if (ins[31:24] == 8'hB4) begin
      if (t == 64'd0) m_pc = m_pc - 64'd4 + sx(64'(ins[23:5]), 19) * 64'd4;
`ifdef CBNZ_EN
    end else if (ins[31:24] == 8'hB5) begin
      if (t != 64'd0) m_pc = m_pc - 64'd4 + sx(64'(ins[23:5]), 19) * 64'd4;
`endif
    end else if (ins[31:26] == 6'h05) begin
      m_pc = m_pc - 64'd4 + sx(64'(ins[25:0]), 26) * 64'd4;
    end
    if (wr && ins[4:0] != 5'd31) m_reg[ins[4:0]] = res;
  endtask

  // Model advances with the DUT: asynchronous reset or one instruction per rising edge.
  initial begin
    forever begin
      @(posedge CLK or negedge Reset_L);
      if (!Reset_L) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (en) begin
        chk("model_pc", currentPC, m_pc);
        chk("model_dmemout", dMemOut, m_out);
      end
    end
  end

  task automatic do_reset(input logic [63:0] spc);
    @(negedge CLK);
    #2;
    startPC = spc;
    Reset_L = 1'b0;
    #1;
    chk("reset_pc", currentPC, spc);
    chk("reset_dmemout", dMemOut, 64'd0);
    repeat (2) @(negedge CLK);
    #2;
    Reset_L = 1'b1;
  endtask

  logic [63:0] seq [12];
  logic [63:0] exp_seq [12];
  bit seen20, seen2c;

  initial begin
    exp_seq = '{64'h00, 64'h04, 64'h08, 64'h0C, 64'h10, 64'h14,
                64'h18, 64'h1C, 64'h24, 64'h28, 64'h30, 64'h34};
    @(negedge CLK);
    en = 1'b1;

    // Program 1 from address 0: PC trace and final load value.
    do_reset(64'd0);
    seq[0] = currentPC;
    for (int k = 1; k < 12; k++) begin
      @(negedge CLK);
      seq[k] = currentPC;
    end
    seen20 = 1'b0;
    seen2c = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("pc_seq[%0d]", k), seq[k], exp_seq[k]);
      if (seq[k] == 64'h20) seen20 = 1'b1;
      if (seq[k] == 64'h2C) seen2c = 1'b1;
    end
    chk("skip_0x20", 64'(seen20), 64'd0);
    chk("skip_0x2c", 64'(seen2c), 64'd0);
    chk("final_dmemout", dMemOut, 64'hF);
    chk("final_pc", currentPC, 64'h34);
    repeat (10) @(negedge CLK);
    chk("halt_pc", currentPC, 64'h34);
    chk("halt_dmemout", dMemOut, 64'hF);

    // Asynchronous reset in the middle of the program.
    do_reset(64'd0);
    for (int k = 0; k < 20 && currentPC != 64'h14; k++) @(negedge CLK);
    chk("reach_pc_0x14", currentPC, 64'h14);
    chk("mid_dmemout", dMemOut, 64'h5);
    #2;
    Reset_L = 1'b0;
    #1;
    chk("async_pc", currentPC, 64'd0);
    chk("async_dmemout", dMemOut, 64'd0);
    @(negedge CLK);
    #2;
    Reset_L = 1'b1;
    repeat (20) @(negedge CLK);
    chk("rerun_dmemout", dMemOut, 64'hF);
    chk("rerun_pc", currentPC, 64'h34);

    // Start at 0x30: dword4 must be back at its initial zero.
    do_reset(64'h30);
    @(negedge CLK);
    chk("start30_dmemout", dMemOut, 64'd0);
    chk("start30_pc", currentPC, 64'h34);

    // Randomized start addresses, run lengths and mid-run resets.
    for (int it = 0; it < 25; it++) begin
      logic [63:0] spc;
      int n, rk;
      if ($urandom_range(0, 3) == 0) spc = {$urandom, $urandom};
      else spc = 64'($urandom_range(0, 20)) * 64'd4;
      do_reset(spc);
      n  = $urandom_range(5, 100);
      rk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : -1;
      for (int c = 0; c < n; c++) begin
        @(negedge CLK);
        if (c == rk) begin
          #($urandom_range(1, 3));
          Reset_L = 1'b0;
          #1;
          chk("rand_async_pc", currentPC, spc);
          chk("rand_async_dmemout", dMemOut, 64'd0);
          @(negedge CLK);
          #2;
          Reset_L = 1'b1;
        end
      end
    end

    @(negedge CLK);
    en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
